sdram_frame_reader: RTL and testbench

- Single-port read-side client for the 4-port SDRAM controller: owns one RD FIFO port (RD, RD_LOAD, RD_ADDR, RD_MAX_ADDR, RD_LENGTH, RD_DATA, RD_EMPTY, RD_USE).
- Turns a raster pixel-demand strobe from display timing into FIFO reads.
- At frame start, reloads the controller port and prefills the FIFO.
- Substitutes fill pixels on underflow so raster alignment is never lost.

---
 rtl/sdram_frame_reader.sv | 131 +++++++++++++
 tb/tb_sdram_frame_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_reader.sv
// Read-side frame client for one SDRAM controller FIFO port: reloads the port at
// frame start, prefills, then turns raster pixel demand into FIFO reads with fill on underflow.
module sdram_frame_reader #(
  parameter int              DSIZE         = 16,
  parameter int              ASIZE         = 22,
  parameter int              FRAME_BASE    = 0,
  parameter int              FRAME_MAX     = 640 * 480,
  parameter int              BURST_LEN     = 256,
  parameter int              H_ACTIVE      = 640,
  parameter int              V_ACTIVE      = 480,
  parameter int              LOAD_CYCLES   = 4,
  parameter int              PREFILL_LEVEL = 128,
  parameter logic [DSIZE-1:0] FILL_PIXEL   = '0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             iFRAME_START,
  input  logic             iPIX_REQ,
  input  logic             iCLR_ERR,
  input  logic [DSIZE-1:0] RD_DATA,
  input  logic             RD_EMPTY,
  input  logic [8:0]       RD_USE,
  output logic             RD,
  output logic             RD_LOAD,
  output logic [ASIZE-1:0] RD_ADDR,
  output logic [ASIZE-1:0] RD_MAX_ADDR,
  output logic [8:0]       RD_LENGTH,
  output logic [DSIZE-1:0] oPIX_DATA,
  output logic             oPIX_VALID,
  output logic [9:0]       oX,
  output logic [9:0]       oY,
  output logic             oFRAME_DONE,
  output logic             oUNDERFLOW,
  output logic [15:0]      oUFL_CNT
);

  typedef enum logic [2:0] {IDLE, LOAD, PREFILL, STREAM, DONE} state_t;

  localparam int         LCW       = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST    = 10'(V_ACTIVE - 1);

  state_t         state, state_nxt;
  logic [LCW-1:0] load_cnt;
  logic           accept, in_stream, adv, ufl, x_last, frame_last;
  logic           req_d1, tag_d1;

  assign RD_ADDR     = ASIZE'(FRAME_BASE);
  assign RD_MAX_ADDR = ASIZE'(FRAME_MAX);
  assign RD_LENGTH   = 9'(BURST_LEN);

  // A frame start swallows any coincident request: it gets a fill pixel and nothing else.
  assign accept     = iPIX_REQ & ~iFRAME_START;
  assign in_stream  = (state == STREAM);
  assign adv        = in_stream & accept;
  assign RD         = adv & ~RD_EMPTY;
  assign RD_LOAD    = (state == LOAD);
  assign ufl        = accept & ((in_stream & RD_EMPTY) | (state == LOAD) | (state == PREFILL));
  assign x_last     = (oX == X_LAST);
  assign frame_last = adv & x_last & (oY == Y_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (iFRAME_START) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (load_cnt == LOAD_LAST)            state_nxt = PREFILL;
        PREFILL: if (RD_USE >= 9'(PREFILL_LEVEL))      state_nxt = STREAM;
        STREAM:  if (frame_last)                       state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      load_cnt    <= '0;
      oX          <= '0;
      oY          <= '0;
      oFRAME_DONE <= 1'b0;
      oUNDERFLOW  <= 1'b0;
      oUFL_CNT    <= '0;
    end else begin
      state       <= state_nxt;
      oFRAME_DONE <= frame_last;

      if (iFRAME_START)          load_cnt <= '0;
      else if (state == LOAD)    load_cnt <= load_cnt + LCW'(1);

      if (iFRAME_START) begin
        oX <= '0;
        oY <= '0;
      end else if (adv) begin
        if (x_last) begin
          oX <= '0;
          oY <= (oY == Y_LAST) ? 10'd0 : oY + 10'd1;
        end else begin
          oX <= oX + 10'd1;
        end
      end

      if (iFRAME_START)                    oUFL_CNT <= '0;
      else if (ufl && oUFL_CNT != 16'hFFFF) oUFL_CNT <= oUFL_CNT + 16'd1;

      // Set beats clear when both land in the same cycle.
      if (ufl)           oUNDERFLOW <= 1'b1;
      else if (iCLR_ERR) oUNDERFLOW <= 1'b0;
    end
  end

  // Fixed two-cycle pixel path; the tag remembers whether a FIFO word was popped for this slot.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req_d1     <= 1'b0;
      tag_d1     <= 1'b0;
      oPIX_VALID <= 1'b0;
      oPIX_DATA  <= '0;
    end else begin
      req_d1     <= iPIX_REQ;
      tag_d1     <= RD;
      oPIX_VALID <= req_d1;
      oPIX_DATA  <= tag_d1 ? RD_DATA : FILL_PIXEL;
    end
  end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader with a small non-showahead FIFO model;
// the frame is shortened to 640x3 so a full frame fits in a short run.
module tb_sdram_frame_reader;

  localparam logic [15:0] FILL = 16'hF11F;
  localparam int          HA   = 640;
  localparam int          VA   = 3;

  logic        CLK = 1'b0;
  logic        RESET_N, iFRAME_START, iPIX_REQ, iCLR_ERR;
  logic [15:0] RD_DATA = '0;
  logic        RD_EMPTY;
  logic [8:0]  RD_USE;
  logic        RD, RD_LOAD, oPIX_VALID, oFRAME_DONE, oUNDERFLOW;
  logic [21:0] RD_ADDR, RD_MAX_ADDR;
  logic [8:0]  RD_LENGTH;
  logic [15:0] oPIX_DATA, oUFL_CNT;
  logic [9:0]  oX, oY;

  int errors = 0;
  int checks = 0;

  sdram_frame_reader #(
    .DSIZE(16), .ASIZE(22), .FRAME_BASE(1024), .FRAME_MAX(HA * VA), .BURST_LEN(256),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOAD_CYCLES(4), .PREFILL_LEVEL(128), .FILL_PIXEL(FILL)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .iFRAME_START(iFRAME_START), .iPIX_REQ(iPIX_REQ),
    .iCLR_ERR(iCLR_ERR), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY), .RD_USE(RD_USE),
    .RD(RD), .RD_LOAD(RD_LOAD), .RD_ADDR(RD_ADDR), .RD_MAX_ADDR(RD_MAX_ADDR),
    .RD_LENGTH(RD_LENGTH), .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID), .oX(oX), .oY(oY),
    .oFRAME_DONE(oFRAME_DONE), .oUNDERFLOW(oUNDERFLOW), .oUFL_CNT(oUFL_CNT)
  );

  always #5 CLK = ~CLK;

  // FIFO model: RD_LOAD clears it; pushes write 1,2,3,... counted from the last clear.
  logic [15:0] mem [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          fifo_cnt;
  logic [15:0] seq = '0;
  logic        push_en = 1'b0;
  logic        auto_fill = 1'b0;

  assign fifo_cnt = wr_ptr - rd_ptr;
  assign RD_EMPTY = (fifo_cnt == 0);
  assign RD_USE   = (fifo_cnt > 511) ? 9'd511 : fifo_cnt[8:0];

  always @(posedge CLK) begin
    if (RD_LOAD) begin
      rd_ptr <= wr_ptr;
      seq    <= '0;
    end else begin
      if (RD && fifo_cnt > 0) begin
        RD_DATA <= mem[rd_ptr[11:0]];
        rd_ptr  <= rd_ptr + 1;
      end
      if (push_en || (auto_fill && fifo_cnt < 200)) begin
        mem[wr_ptr[11:0]] <= seq + 16'd1;
        seq               <= seq + 16'd1;
        wr_ptr            <= wr_ptr + 1;
      end
    end
  end

  task automatic frame_start_pulse();
    @(negedge CLK);
    iFRAME_START = 1'b1;
    @(negedge CLK);
    iFRAME_START = 1'b0;
  endtask

  // Leaves the bench at the first negedge with the DUT in STREAM.
  task automatic enter_stream(input bit use_auto);
    int n;
    n = 0;
    while (RD_LOAD !== 1'b0 && n < 50) begin @(negedge CLK); n++; end
    if (use_auto) auto_fill = 1'b1;
    else          push_en   = 1'b1;
    n = 0;
    while (RD_USE < 9'd128 && n < 400) begin @(negedge CLK); n++; end
    push_en = 1'b0;
    checks++;
    if (RD_USE < 9'd128 || n >= 400) begin
      errors++;
      $display("FAIL enter_stream_timeout: RD_USE=%0d RD_LOAD=%b, required RD_USE>=128", RD_USE, RD_LOAD);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; iFRAME_START = 1'b0; iPIX_REQ = 1'b0; iCLR_ERR = 1'b0;
    #2;
    checks++; if ({RD, RD_LOAD, oPIX_VALID, oFRAME_DONE, oUNDERFLOW} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: RD/LOAD/VALID/DONE/UFL=%b required 00000", {RD, RD_LOAD, oPIX_VALID, oFRAME_DONE, oUNDERFLOW}); end
    checks++; if ({oX, oY, oUFL_CNT, oPIX_DATA} !== 52'd0) begin errors++;
      $display("FAIL reset_regs: oX=%0d oY=%0d ufl=%0d data=%h required all 0", oX, oY, oUFL_CNT, oPIX_DATA); end
    checks++; if (RD_ADDR !== 22'd1024 || RD_MAX_ADDR !== 22'd1920 || RD_LENGTH !== 9'd256) begin errors++;
      $display("FAIL static_ports: addr=%0d max=%0d len=%0d required 1024/1920/256", RD_ADDR, RD_MAX_ADDR, RD_LENGTH); end
    @(negedge CLK);
    RESET_N = 1'b1;
    // A request in IDLE returns a fill pixel without counting as underflow.
    @(negedge CLK); iPIX_REQ = 1'b1;
    @(negedge CLK); iPIX_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== FILL || oUFL_CNT !== 16'd0) begin errors++;
      $display("FAIL idle_req: valid=%b data=%h ufl=%0d required 1/%h/0", oPIX_VALID, oPIX_DATA, oUFL_CNT, FILL); end
    @(negedge CLK);
    checks++; if (oPIX_VALID !== 1'b0) begin errors++;
      $display("FAIL idle_valid_drop: valid=%b required 0", oPIX_VALID); end
  endtask

  task automatic test_load_prefill();
    int n;
    frame_start_pulse();
    checks++; if (RD_LOAD !== 1'b1) begin errors++; $display("FAIL load_start: RD_LOAD=%b required 1", RD_LOAD); end
    @(negedge CLK);
    iFRAME_START = 1'b1;
    @(negedge CLK);
    iFRAME_START = 1'b0;
    n = 0;
    while (RD_LOAD === 1'b1 && n < 20) begin n++; @(negedge CLK); end
    checks++; if (n != 4) begin errors++; $display("FAIL load_width: RD_LOAD high %0d clocks after restart, required 4", n); end
    push_en = 1'b1;
    n = 0;
    while (RD_USE != 9'd10 && n < 50) begin @(negedge CLK); n++; end
    iPIX_REQ = 1'b1;
    #1;
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL prefill_no_rd: RD=%b at RD_USE=%0d required 0", RD, RD_USE); end
    @(negedge CLK);
    iPIX_REQ = 1'b0;
    n = 0;
    while (RD_USE != 9'd128 && n < 300) begin @(negedge CLK); n++; end
    push_en  = 1'b0;
    iPIX_REQ = 1'b1;
    #1;
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL prefill_edge_rd: RD=%b at RD_USE=%0d required 0", RD, RD_USE); end
    @(negedge CLK);
    #1;
    checks++; if (RD !== 1'b1) begin errors++; $display("FAIL stream_entry_rd: RD=%b one cycle after RD_USE=128, required 1", RD); end
    @(negedge CLK);
    iPIX_REQ = 1'b0;
    checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== FILL) begin errors++;
      $display("FAIL prefill_pixel: valid=%b data=%h required 1/%h", oPIX_VALID, oPIX_DATA, FILL); end
    @(negedge CLK);
    checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== 16'h0001) begin errors++;
      $display("FAIL first_stream_pixel: valid=%b data=%h required 1/0001", oPIX_VALID, oPIX_DATA); end
    checks++; if (oUFL_CNT !== 16'd2 || oUNDERFLOW !== 1'b1) begin errors++;
      $display("FAIL prefill_underflow: cnt=%0d flag=%b required 2/1", oUFL_CNT, oUNDERFLOW); end
  endtask

  task automatic test_stream_line();
    frame_start_pulse();
    enter_stream(1'b0);
    push_en = 1'b1;
    repeat (512) @(negedge CLK);
    push_en  = 1'b0;
    iCLR_ERR = 1'b1;
    @(negedge CLK);
    iCLR_ERR = 1'b0;
    checks++; if (oUNDERFLOW !== 1'b0 || oUFL_CNT !== 16'd0) begin errors++;
      $display("FAIL line_pre_flags: flag=%b cnt=%0d required 0/0", oUNDERFLOW, oUFL_CNT); end
    for (int i = 0; i < HA + 2; i++) begin
      if (i >= 2) begin
        checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== 16'(i - 1)) begin errors++;
          $display("FAIL line_pixel[%0d]: valid=%b data=%h required 1/%h", i - 2, oPIX_VALID, oPIX_DATA, 16'(i - 1)); end
      end
      if (i == 0 || i == HA - 1 || i == HA) begin
        checks++; if (oX !== 10'(i % HA) || oY !== 10'(i / HA)) begin errors++;
          $display("FAIL line_xy@%0d: oX=%0d oY=%0d required %0d/%0d", i, oX, oY, i % HA, i / HA); end
      end
      iPIX_REQ = (i < HA);
      @(negedge CLK);
    end
    checks++; if (oUNDERFLOW !== 1'b0 || oUFL_CNT !== 16'd0 || RD_EMPTY !== 1'b1) begin errors++;
      $display("FAIL line_post: flag=%b cnt=%0d empty=%b required 0/0/1", oUNDERFLOW, oUFL_CNT, RD_EMPTY); end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== FILL) begin errors++;
          $display("FAIL ufl_pixel[%0d]: valid=%b data=%h required 1/%h", i - 2, oPIX_VALID, oPIX_DATA, FILL); end
      end
      iPIX_REQ = (i < 3);
      #1;
      if (i < 3) begin
        checks++; if (RD !== 1'b0) begin errors++; $display("FAIL ufl_rd[%0d]: RD=%b required 0", i, RD); end
      end
      @(negedge CLK);
    end
    checks++; if (oUFL_CNT !== 16'd3 || oUNDERFLOW !== 1'b1 || oX !== 10'd3 || oY !== 10'd1) begin errors++;
      $display("FAIL ufl_state: cnt=%0d flag=%b oX=%0d oY=%0d required 3/1/3/1", oUFL_CNT, oUNDERFLOW, oX, oY); end
    iCLR_ERR = 1'b1;
    @(negedge CLK);
    iCLR_ERR = 1'b0;
    checks++; if (oUNDERFLOW !== 1'b0 || oUFL_CNT !== 16'd3) begin errors++;
      $display("FAIL ufl_clear: flag=%b cnt=%0d required 0/3", oUNDERFLOW, oUFL_CNT); end
    iCLR_ERR = 1'b1; iPIX_REQ = 1'b1;
    @(negedge CLK);
    iCLR_ERR = 1'b0; iPIX_REQ = 1'b0;
    checks++; if (oUNDERFLOW !== 1'b1 || oUFL_CNT !== 16'd4) begin errors++;
      $display("FAIL ufl_set_wins: flag=%b cnt=%0d required 1/4", oUNDERFLOW, oUFL_CNT); end
  endtask

  task automatic test_frame_start_midline();
    for (int i = 0; i < 96; i++) begin
      iPIX_REQ = 1'b1;
      @(negedge CLK);
    end
    iPIX_REQ = 1'b0;
    push_en  = 1'b1;
    repeat (4) @(negedge CLK);
    push_en  = 1'b0;
    iCLR_ERR = 1'b1;
    @(negedge CLK);
    iCLR_ERR = 1'b0;
    checks++; if (oX !== 10'd100 || oUNDERFLOW !== 1'b0 || RD_EMPTY !== 1'b0) begin errors++;
      $display("FAIL midline_setup: oX=%0d flag=%b empty=%b required 100/0/0", oX, oUNDERFLOW, RD_EMPTY); end
    iFRAME_START = 1'b1; iPIX_REQ = 1'b1;
    #1;
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL midline_rd: RD=%b required 0", RD); end
    @(negedge CLK);
    iFRAME_START = 1'b0; iPIX_REQ = 1'b0;
    checks++; if (oX !== 10'd0 || oY !== 10'd0 || oUFL_CNT !== 16'd0 || RD_LOAD !== 1'b1) begin errors++;
      $display("FAIL midline_restart: oX=%0d oY=%0d cnt=%0d load=%b required 0/0/0/1", oX, oY, oUFL_CNT, RD_LOAD); end
    @(negedge CLK);
    checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== FILL || oUNDERFLOW !== 1'b0 || oUFL_CNT !== 16'd0) begin errors++;
      $display("FAIL midline_pixel: valid=%b data=%h flag=%b cnt=%0d required 1/%h/0/0", oPIX_VALID, oPIX_DATA, oUNDERFLOW, oUFL_CNT, FILL); end
  endtask

  task automatic test_full_frame();
    int pulses;
    enter_stream(1'b1);
    pulses = 0;
    for (int i = 0; i < HA * VA + 6; i++) begin
      if (i >= 2 && i < HA * VA + 2) begin
        checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== 16'(i - 1)) begin errors++;
          $display("FAIL frame_pixel[%0d]: valid=%b data=%h required 1/%h", i - 2, oPIX_VALID, oPIX_DATA, 16'(i - 1)); end
      end
      if (oFRAME_DONE === 1'b1) pulses++;
      checks++; if (oFRAME_DONE !== (i == HA * VA)) begin errors++;
        $display("FAIL frame_done@%0d: oFRAME_DONE=%b required %b", i, oFRAME_DONE, i == HA * VA); end
      iPIX_REQ = (i < HA * VA);
      @(negedge CLK);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL frame_done_count: %0d pulses required 1", pulses); end
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        checks++; if (oPIX_VALID !== 1'b1 || oPIX_DATA !== FILL) begin errors++;
          $display("FAIL done_pixel[%0d]: valid=%b data=%h required 1/%h", i - 2, oPIX_VALID, oPIX_DATA, FILL); end
      end
      iPIX_REQ = (i < 3);
      #1;
      if (i < 3) begin
        checks++; if (RD !== 1'b0) begin errors++; $display("FAIL done_rd[%0d]: RD=%b required 0", i, RD); end
      end
      @(negedge CLK);
    end
    checks++; if (oUFL_CNT !== 16'd0 || oUNDERFLOW !== 1'b0 || oFRAME_DONE !== 1'b0) begin errors++;
      $display("FAIL done_flags: cnt=%0d flag=%b done=%b required 0/0/0", oUFL_CNT, oUNDERFLOW, oFRAME_DONE); end
  endtask

  task automatic test_reset_mid_stream();
    frame_start_pulse();
    enter_stream(1'b1);
    iPIX_REQ = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (RD !== 1'b1 || oX !== 10'd3) begin errors++;
      $display("FAIL pre_reset: RD=%b oX=%0d required 1/3", RD, oX); end
    RESET_N = 1'b0;
    #1;
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL reset_rd: RD=%b during reset, required 0", RD); end
    iPIX_REQ = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++; if (oPIX_VALID !== 1'b0 || RD_LOAD !== 1'b0 || oX !== 10'd0 || oY !== 10'd0 || RD !== 1'b0) begin errors++;
      $display("FAIL post_reset: valid=%b load=%b oX=%0d oY=%0d RD=%b required 0/0/0/0/0", oPIX_VALID, RD_LOAD, oX, oY, RD); end
    // IDLE after reset: a request with data available must not read the FIFO.
    iPIX_REQ = 1'b1;
    #1;
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL post_reset_idle_rd: RD=%b required 0", RD); end
    @(negedge CLK);
    iPIX_REQ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_prefill();
    test_stream_line();
    test_underflow();
    test_frame_start_midline();
    test_full_frame();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
